// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - MSB-first parallel-to-serial converter with a one-word holding register
// Optional even-parity bit after each word's LSB when PISO_PARITY_EN is defined.
module piso_serializer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             frame,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh_data;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             accept;
  logic             frame_end;
  logic             shift_step;
  logic             reload;
  logic             load_hold;
  logic             load_in;
  logic             load;
  logic             hold_wr;
  logic             go_idle;
  logic [WIDTH-1:0] load_word;
`ifdef PISO_PARITY_EN
  logic             par_bit;
`endif

  assign in_ready = !hold_full && !reset;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cnt == '0) begin
`ifdef PISO_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = (hold_full || accept) ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: state_nxt = (hold_full || accept) ? SHIFT : IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // The reload edge is the last edge of a frame: either LSB->next MSB or parity->next MSB.
  always_comb begin
    frame_end  = (state == SHIFT) && (cnt == '0);
    shift_step = (state == SHIFT) && (cnt != '0);
`ifdef PISO_PARITY_EN
    reload     = (state == PARITY);
`else
    reload     = frame_end;
`endif
    load_hold  = reload && hold_full;
    load_in    = accept && ((state == IDLE) || (reload && !hold_full));
    load       = load_hold || load_in;
    hold_wr    = accept && (state == SHIFT) && !reload;
    go_idle    = reload && !load;
    load_word  = load_hold ? hold_data : in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_data   <= '0;
      cnt       <= '0;
      ser_out   <= 1'b0;
      frame     <= 1'b0;
      busy      <= 1'b0;
      hold_full <= 1'b0;
      hold_data <= '0;
`ifdef PISO_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      // sh_data holds the bits still to be sent, left-aligned, so the MSB is always next.
      if (load) begin
        sh_data <= load_word << 1;
        ser_out <= load_word[WIDTH-1];
        frame   <= 1'b1;
        busy    <= 1'b1;
        cnt     <= CNT_LOAD;
`ifdef PISO_PARITY_EN
        par_bit <= ^load_word;
`endif
      end else if (shift_step) begin
        sh_data <= sh_data << 1;
        ser_out <= sh_data[WIDTH-1];
        frame   <= 1'b0;
        cnt     <= cnt - CW'(1);
`ifdef PISO_PARITY_EN
      end else if (frame_end) begin
        ser_out <= par_bit;
        frame   <= 1'b0;
`endif
      end else if (go_idle) begin
        ser_out <= 1'b0;
        frame   <= 1'b0;
        busy    <= 1'b0;
      end

      if (load_hold) begin
        hold_full <= 1'b0;
      end else if (hold_wr) begin
        hold_full <= 1'b1;
        hold_data <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed and random checks of piso_serializer against a bit-queue model
// Frame length follows PISO_PARITY_EN.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int FL = 17;
`else
  localparam int FL = 16;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        ser_out;
  logic        frame;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Model: queue of {bit, frame_flag} still to appear on ser_out; head is the current bit.
  logic [1:0]  m_q[$];
  logic        m_held = 1'b0;
  logic [15:0] m_hw   = '0;

  piso_serializer #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ser_out  (ser_out),
    .frame    (frame),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_frame(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) m_q.push_back({w[i], (i == 15) ? 1'b1 : 1'b0});
`ifdef PISO_PARITY_EN
    m_q.push_back({^w, 1'b0});
`endif
  endfunction

  // One clock: drive inputs, check in_ready, step the model at the edge, check outputs.
  task automatic cyc(input logic r, input logic v, input logic [15:0] d, output logic acc);
    logic exp_ser, exp_frm, exp_busy;
    reset = r; in_valid = v; in_data = d;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_held && !r));
    acc = v && !m_held && !r;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_held = 1'b0;
    end else begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        if (m_held) begin
          push_frame(m_hw);
          m_held = 1'b0;
        end else if (acc) begin
          push_frame(d);
        end
      end else if (acc) begin
        m_held = 1'b1;
        m_hw   = d;
      end
    end
    #1;
    exp_ser  = (m_q.size() > 0) ? m_q[0][1] : 1'b0;
    exp_frm  = (m_q.size() > 0) ? m_q[0][0] : 1'b0;
    exp_busy = (m_q.size() > 0);
    chk("ser_out", 32'(ser_out), 32'(exp_ser));
    chk("frame", 32'(frame), 32'(exp_frm));
    chk("busy", 32'(busy), 32'(exp_busy));
  endtask

  initial begin
    logic        acc;
    logic [15:0] obs;
    logic [15:0] words [3];
    int          nf, nb, idx, nfr;
    int          fpos [3];

    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    @(posedge clk); #1;

    // Reset state
    cyc(1'b1, 1'b1, 16'hFFFF, acc);
    chk("rst_ser", 32'(ser_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single word
    cyc(1'b0, 1'b1, 16'hA518, acc);
    obs = {15'd0, ser_out}; nf = int'(frame); nb = int'(busy);
    for (int i = 1; i < 16; i++) begin
      cyc(1'b0, 1'b0, 16'h0, acc);
      obs = {obs[14:0], ser_out}; nf += int'(frame); nb += int'(busy);
    end
    chk("a518_bits", 32'(obs), 32'h0000A518);
    chk("a518_frames", 32'(nf), 32'd1);
    chk("a518_busy", 32'(nb), 32'd16);
`ifdef PISO_PARITY_EN
    cyc(1'b0, 1'b0, 16'h0, acc);
    chk("a518_parity", 32'(ser_out), 32'd0);
    chk("a518_par_busy", 32'(busy), 32'd1);
`endif
    cyc(1'b0, 1'b0, 16'h0, acc);
    chk("a518_end_busy", 32'(busy), 32'd0);
    chk("a518_end_ser", 32'(ser_out), 32'd0);

    // Back-to-back streaming
    words[0] = 16'hA518; words[1] = 16'h5A5A; words[2] = 16'hFFFF;
    idx = 0; nb = 0; nfr = 0;
    for (int c = 1; c <= 3 * FL + 2; c++) begin
      cyc(1'b0, idx < 3, (idx < 3) ? words[idx] : 16'h0, acc);
      if (acc) idx++;
      nb += int'(busy);
      if (frame && nfr < 3) begin
        fpos[nfr] = c;
        nfr++;
      end
    end
    chk("b2b_busy", 32'(nb), 32'(3 * FL));
    chk("b2b_f0", 32'(fpos[0]), 32'd1);
    chk("b2b_f1", 32'(fpos[1]), 32'(1 + FL));
    chk("b2b_f2", 32'(fpos[2]), 32'(1 + 2 * FL));

    // Hold and gap-free reload
    cyc(1'b0, 1'b1, 16'hA518, acc);
    cyc(1'b0, 1'b1, 16'h1234, acc);
    chk("hold_ready", 32'(in_ready), 32'd0);
    for (int c = 3; c <= FL; c++) cyc(1'b0, 1'b0, 16'h0, acc);
    cyc(1'b0, 1'b0, 16'h0, acc);
    chk("hold_frame", 32'(frame), 32'd1);
    obs = {15'd0, ser_out};
    for (int i = 1; i < 16; i++) begin
      cyc(1'b0, 1'b0, 16'h0, acc);
      obs = {obs[14:0], ser_out};
    end
    chk("hold_bits", 32'(obs), 32'h00001234);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 16'h0, acc);

    // Reset mid-frame with a word held
    cyc(1'b0, 1'b1, 16'hA518, acc);
    cyc(1'b0, 1'b1, 16'h1234, acc);
    for (int c = 3; c <= 6; c++) cyc(1'b0, 1'b0, 16'h0, acc);
    cyc(1'b1, 1'b0, 16'h0, acc);
    chk("rst_mid_ser", 32'(ser_out), 32'd0);
    chk("rst_mid_frame", 32'(frame), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 16'h0, acc);
      nb += int'(busy);
    end
    chk("rst_held_lost", 32'(nb), 32'd0);
    cyc(1'b0, 1'b1, 16'h5A5A, acc);
    chk("rst_new_frame", 32'(frame), 32'd1);
    obs = {15'd0, ser_out};
    for (int i = 1; i < 16; i++) begin
      cyc(1'b0, 1'b0, 16'h0, acc);
      obs = {obs[14:0], ser_out};
    end
    chk("rst_new_bits", 32'(obs), 32'h00005A5A);

    // Idle reload: frame drains, word arrives later
    for (int i = 0; i < FL - 15 + 3; i++) cyc(1'b0, 1'b0, 16'h0, acc);
    chk("idle_busy", 32'(busy), 32'd0);
    cyc(1'b0, 1'b1, 16'hC3C3, acc);
    chk("idle_msb", 32'(ser_out), 32'd1);
    chk("idle_frame", 32'(frame), 32'd1);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) < 6),
          16'($urandom), acc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out serializer that drives the serial input of the team's 16-bit deserializer. It accepts parallel words over a valid/ready handshake and buffers one word in a holding register. It emits each word MSB-first, one bit per clock, with a frame strobe on the first bit. Back-to-back words stream with no idle cycle between frames, so the receiver's free-running 16-bit bit counter stays aligned.

## Interface
- WIDTH, 16: word width in bits; legal range 2..64.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; clock clk.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  combinational; = !hold_full && !reset.
- ser_out  output  1  registered serial bit.
- frame  output  1  registered; high during the cycle ser_out carries a word's MSB.
- busy  output  1  registered; high whenever ser_out carries a valid bit (data or parity).

## Operation
- Acceptance: a word is accepted at a rising edge where in_valid && in_ready.
- Internal state:
  - shifter sh_data[WIDTH-1:0] and bit counter cnt (clog2(WIDTH+1) bits);
  - holding register hold_data with hold_full flag;
  - FSM with states IDLE, SHIFT and PARITY (PARITY exists only when the macro is defined).
- IDLE:
  - An accepted word loads the shifter directly; it does not pass through the holding register.
  - At that edge: ser_out<=in_data[WIDTH-1], frame<=1, busy<=1, cnt<=WIDTH-1, next state SHIFT.
- SHIFT, with cnt!=0:
  - Each edge: ser_out<=next bit, frame<=0, cnt<=cnt-1.
  - A word accepted in this state goes to the holding register (hold_full<=1).
- SHIFT, last bit (cnt==0), called the frame-end edge:
  - If PARITY is enabled, go to PARITY; ser_out<=even-parity bit.
  - Otherwise, perform the reload decision.
- PARITY: the next edge performs the reload decision.
- Reload decision, evaluated in priority order:
  1. hold_full: load hold_data into the shifter and clear hold_full. in_ready is 0 at this edge, so no new word is accepted.
  2. Else if in_valid && in_ready: load in_data into the shifter directly.
  3. Else: state IDLE, ser_out<=0, frame<=0, busy<=0.
  - A loaded frame follows the IDLE-load rules: MSB on ser_out, frame=1.
- Simultaneous events: at most one word is accepted per edge. A word accepted at the reload edge bypasses the holding register, so the holding register never overflows.
- Reset (any state, including mid-frame):
  - The current frame is aborted and the held word is discarded. No partial frame resumes.
  - Reset values: ser_out=0, frame=0, busy=0, hold_full=0, state IDLE.
  - in_ready=0 while reset is high and 1 in the first cycle after release.

## Timing
- Latency: a word accepted at edge N shows its MSB on ser_out in cycle N+1 (visible after edge N).
- Frame length: WIDTH cycles without parity, WIDTH+1 cycles with parity.
- Streaming: consecutive frames are gap-free when the next word is held or presented by the reload edge.
- Throughput: one word per frame length.
- in_ready falls the cycle after a word enters the holding register. It rises the cycle after the reload edge that empties it.
- in_data and in_valid are sampled only at acceptance edges. in_data may change freely otherwise.

## Configuration
- PISO_PARITY_EN defined:
  - An even-parity bit (XOR of all WIDTH data bits) follows each word's LSB for one cycle.
  - busy=1 and frame=0 during the parity cycle.
  - Frame length becomes WIDTH+1.
- PISO_PARITY_EN undefined:
  - The PARITY state and its logic are absent; frame length is WIDTH.
  - This is the required mode when feeding the 16-bit deserializer, which has no parity slot.

## Test plan
- Single word, WIDTH=16, parity off: accept 16'hA518 in IDLE -> ser_out over cycles 1..16 = 1,0,1,0,0,1,0,1,0,0,0,1,1,0,0,0. frame=1 only in cycle 1, busy=1 in cycles 1..16, then ser_out=0 and busy=0.
- Back-to-back: in_valid held high with 16'hA518, 16'h5A5A, 16'hFFFF -> 48 consecutive busy cycles with no gap. frame pulses at cycles 1, 17, 33. in_ready is 0 while a word is held.
- Backpressure and hold: present 16'h1234 in cycle 2 of a frame -> accepted into hold, in_ready=0 until the frame-end reload. 16'h1234 MSB appears in the cycle immediately after the prior frame's LSB.
- Parity (PISO_PARITY_EN): 16'hA518 -> 16 data bits then parity 0. 16'h0001 -> parity 1. Frame pulses 17 cycles apart when streaming.
- Reset mid-frame: assert reset in cycle 7 of 16'hA518 with a word held -> next edge ser_out=0, frame=0, busy=0. Held word lost. in_ready=1 after release; the next accepted word starts a clean frame.
- Idle reload: frame ends with no word held and in_valid=0 -> busy drops to 0. A word presented 3 cycles later has its MSB on ser_out one cycle after acceptance.
